// File: rtl/writeback_queue.sv
// In-order writeback queue: accepts up to LANES results per cycle into a circular buffer,
// retires two per cycle to the register file, and pulses a flush on a retiring redirect.

module writeback_queue_lane #(
   parameter int PW = 3,
   parameter int OW = 3
) (
   input  logic          valid,
   input  logic [PW-1:0] tail,
   input  logic [OW-1:0] offset,
   output logic          we,
   output logic [PW-1:0] slot
);
   // offset is the number of valid lanes below this one, so valid lanes pack densely
   assign we   = valid;
   assign slot = tail + PW'(offset);
endmodule

module writeback_queue #(
   parameter int DEPTH = 8,
   parameter int LANES = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [LANES-1:0]       res_valid,
   input  logic [LANES-1:0][5:0]  res_rd,
   input  logic [LANES-1:0][63:0] res_data,
   input  logic [LANES-1:0]       res_redirect,
   input  logic [LANES-1:0][63:0] res_target,
   output logic                   in_ready,
   output logic [1:0]             wr_en,
   output logic [1:0][5:0]        wr_addr,
   output logic [1:0][63:0]       wr_data,
   output logic [1:0]             retired,
   output logic                   flush_valid,
   output logic [63:0]            flush_target
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(LANES) + 1;

   typedef struct packed {
      logic [5:0]  rd;
      logic [63:0] data;
      logic        redirect;
      logic [63:0] target;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q;

   logic [OW-1:0]            pre [LANES+1];
   logic [OW-1:0]            enq;
   logic [LANES-1:0]         lane_we;
   logic [LANES-1:0][PW-1:0] lane_slot;

   entry_t      e0, e1;
   logic        ret0, ret1, wen0, wen1, flush;
   logic [1:0]  deq;
   logic [63:0] ftarget;

   function automatic logic writable(input logic [5:0] rd);
      return (rd != 6'd0) && (rd != 6'd63);
   endfunction

   // Space is judged on registered count only; a same-cycle retire does not help
   assign in_ready = reset_n && (count_q <= CW'(DEPTH - LANES));

   always_comb begin
      pre[0] = '0;
      for (int i = 0; i < LANES; i++) pre[i+1] = pre[i] + OW'(res_valid[i]);
      enq = in_ready ? pre[LANES] : '0;
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      writeback_queue_lane #(.PW(PW), .OW(OW)) u_lane (
         .valid  (res_valid[g] & in_ready),
         .tail   (tail_q),
         .offset (pre[g]),
         .we     (lane_we[g]),
         .slot   (lane_slot[g])
      );
   end

   always_comb begin
      e0      = mem[head_q];
      e1      = mem[head_q + PW'(1)];
      ret0    = (count_q != '0);
      // A redirect on the older entry ends the retire group
      ret1    = ret0 && !e0.redirect && (count_q >= CW'(2));
      flush   = (ret0 && e0.redirect) || (ret1 && e1.redirect);
      ftarget = e0.redirect ? e0.target : e1.target;
      wen1    = ret1 && writable(e1.rd);
      wen0    = ret0 && writable(e0.rd) && !(wen1 && (e1.rd == e0.rd));
      deq     = {1'b0, ret0} + {1'b0, ret1};
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < LANES; i++)
         if (lane_we[i])
            mem[lane_slot[i]] <= '{rd: res_rd[i], data: res_data[i],
                                   redirect: res_redirect[i], target: res_target[i]};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         wr_en        <= '0;
         wr_addr      <= '0;
         wr_data      <= '0;
         retired      <= '0;
         flush_valid  <= 1'b0;
         flush_target <= '0;
      end else begin
         if (flush) begin
            // Everything younger than the redirect, including this cycle's enqueue, is dropped
            head_q  <= tail_q;
            count_q <= '0;
         end else begin
            head_q  <= head_q + PW'(deq);
            tail_q  <= tail_q + PW'(enq);
            count_q <= count_q + CW'(enq) - CW'(deq);
         end
         wr_en       <= {wen1, wen0};
         wr_addr[0]  <= e0.rd;
         wr_addr[1]  <= e1.rd;
         wr_data[0]  <= e0.data;
         wr_data[1]  <= e1.data;
         retired     <= deq;
         flush_valid <= flush;
         if (flush) flush_target <= ftarget;
      end
   end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: vector table for single-group patterns,
// hand sequences for burst, back-pressure, reset and redirect.

module tb_writeback_queue;
   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic [3:0]          res_valid = '0;
   logic [3:0][5:0]     res_rd = '0;
   logic [3:0][63:0]    res_data = '0;
   logic [3:0]          res_redirect = '0;
   logic [3:0][63:0]    res_target = '0;
   logic                in_ready;
   logic [1:0]          wr_en;
   logic [1:0][5:0]     wr_addr;
   logic [1:0][63:0]    wr_data;
   logic [1:0]          retired;
   logic                flush_valid;
   logic [63:0]         flush_target;

   int ncmp = 0;
   int nbad = 0;

   writeback_queue dut (
      .clock(clock), .reset_n(reset_n),
      .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
      .res_redirect(res_redirect), .res_target(res_target),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .retired(retired), .flush_valid(flush_valid), .flush_target(flush_target)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]       v;
      logic [3:0][5:0]  rd;
      logic [3:0][63:0] data;
      logic [3:0]       redir;
      logic [63:0]      tgt;
      logic [1:0]       x_wen;
      logic [5:0]       x_a0;
      logic [63:0]      x_d0;
      logic [5:0]       x_a1;
      logic [63:0]      x_d1;
      logic [1:0]       x_ret;
      logic             x_fl;
      logic [63:0]      x_ft;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      res_valid = '0; res_rd = '0; res_data = '0; res_redirect = '0; res_target = '0;
   endtask

   logic [5:0]  exp_rd [40];
   logic [63:0] exp_d  [40];
   int nw;

   task automatic collect();
      for (int p = 0; p < 2; p++)
         if (wr_en[p]) begin
            if (nw < 40) begin
               chk("bp_addr", wr_addr[p], exp_rd[nw]);
               chk("bp_data", wr_data[p], exp_d[nw]);
            end else
               chk("bp_extra_write", nw, 40);
            nw++;
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv [6];
      int   g;
      logic rdy;

      tv[0] = '{4'b1010, {6'd0, 6'd0, 6'd7, 6'd50}, {64'hBB, 64'h0, 64'hAA, 64'hDEAD}, 4'b0, 64'h0,
                2'b01, 6'd7, 64'hAA, 6'd0, 64'h0, 2'd2, 1'b0, 64'h0};
      tv[1] = '{4'b1010, {6'd63, 6'd0, 6'd7, 6'd50}, {64'hBB, 64'h0, 64'hAA, 64'hDEAD}, 4'b0, 64'h0,
                2'b01, 6'd7, 64'hAA, 6'd0, 64'h0, 2'd2, 1'b0, 64'h0};
      tv[2] = '{4'b0011, {6'd0, 6'd0, 6'd5, 6'd5}, {64'h0, 64'h0, 64'hB, 64'hA}, 4'b0, 64'h0,
                2'b10, 6'd0, 64'h0, 6'd5, 64'hB, 2'd2, 1'b0, 64'h0};
      tv[3] = '{4'b0100, {6'd0, 6'd9, 6'd0, 6'd0}, {64'h0, 64'h99, 64'h0, 64'h0}, 4'b0, 64'h0,
                2'b01, 6'd9, 64'h99, 6'd0, 64'h0, 2'd1, 1'b0, 64'h0};
      tv[4] = '{4'b0011, {6'd0, 6'd0, 6'd11, 6'd10}, {64'h0, 64'h0, 64'h6, 64'h5}, 4'b0001, 64'h2000,
                2'b01, 6'd10, 64'h5, 6'd0, 64'h0, 2'd1, 1'b1, 64'h2000};
      tv[5] = '{4'b0111, {6'd0, 6'd14, 6'd13, 6'd12}, {64'h0, 64'h3, 64'h2, 64'h1}, 4'b0010, 64'h3000,
                2'b11, 6'd12, 64'h1, 6'd13, 64'h2, 2'd2, 1'b1, 64'h3000};

      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data0", wr_data[0], 0);
      chk("rst_retired", retired, 0);
      chk("rst_flush", flush_valid, 0);
      chk("rst_flush_target", flush_target, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      chk("rst_release_ready", in_ready, 1);

      // Table: one group into an empty queue, check first retire, then drain
      for (int i = 0; i < 6; i++) begin
         res_valid = tv[i].v; res_rd = tv[i].rd; res_data = tv[i].data;
         res_redirect = tv[i].redir; res_target = {4{tv[i].tgt}};
         chk("vec_ready", in_ready, 1);
         tick();
         clr();
         tick();
         chk($sformatf("vec%0d_wr_en", i), wr_en, tv[i].x_wen);
         if (tv[i].x_wen[0]) begin
            chk($sformatf("vec%0d_addr0", i), wr_addr[0], tv[i].x_a0);
            chk($sformatf("vec%0d_data0", i), wr_data[0], tv[i].x_d0);
         end
         if (tv[i].x_wen[1]) begin
            chk($sformatf("vec%0d_addr1", i), wr_addr[1], tv[i].x_a1);
            chk($sformatf("vec%0d_data1", i), wr_data[1], tv[i].x_d1);
         end
         chk($sformatf("vec%0d_retired", i), retired, tv[i].x_ret);
         chk($sformatf("vec%0d_flush", i), flush_valid, tv[i].x_fl);
         if (tv[i].x_fl) chk($sformatf("vec%0d_ftarget", i), flush_target, tv[i].x_ft);
         for (int k = 0; k < 3; k++) tick();
         chk($sformatf("vec%0d_drained_wr_en", i), wr_en, 0);
         chk($sformatf("vec%0d_drained_retired", i), retired, 0);
      end

      // Burst: two retire cycles in order
      res_valid = 4'b1111; res_rd = {6'd4, 6'd3, 6'd2, 6'd1};
      res_data = {64'h44, 64'h33, 64'h22, 64'h11};
      tick();
      clr();
      tick();
      chk("burst1_wr_en", wr_en, 2'b11);
      chk("burst1_addr", wr_addr, {6'd2, 6'd1});
      chk("burst1_data0", wr_data[0], 64'h11);
      chk("burst1_data1", wr_data[1], 64'h22);
      chk("burst1_retired", retired, 2);
      tick();
      chk("burst2_wr_en", wr_en, 2'b11);
      chk("burst2_addr", wr_addr, {6'd4, 6'd3});
      chk("burst2_data0", wr_data[0], 64'h33);
      chk("burst2_data1", wr_data[1], 64'h44);
      chk("burst2_retired", retired, 2);
      tick();
      chk("burst_empty", wr_en, 0);

      // Back-pressure: 40 results offered as 4-lane groups every cycle
      for (int k = 0; k < 40; k++) begin
         exp_rd[k] = 6'(k + 1);
         exp_d[k]  = 64'h100 + 64'(k);
      end
      nw = 0;
      g = 0;
      for (int c = 0; c < 80 && (g < 10 || nw < 40); c++) begin
         if (g < 10) begin
            res_valid = 4'b1111;
            for (int l = 0; l < 4; l++) begin
               res_rd[l]   = exp_rd[g*4 + l];
               res_data[l] = exp_d[g*4 + l];
            end
            if (c < 16) chk("bp_ready", in_ready, (c == 0) || (c % 2 == 1));
         end else
            clr();
         rdy = in_ready;
         tick();
         collect();
         if (g < 10 && rdy) g++;
      end
      clr();
      chk("bp_total_writes", nw, 40);

      // Reset mid-stream
      res_valid = 4'b1111; res_rd = {6'd23, 6'd22, 6'd21, 6'd20};
      res_data = {64'h4, 64'h3, 64'h2, 64'h1};
      tick();
      clr();
      tick();
      chk("rstmid_pre_wr_en", wr_en, 2'b11);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_wr_en", wr_en, 0);
      chk("rstmid_retired", retired, 0);
      chk("rstmid_in_ready", in_ready, 0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rstmid_no_stale", wr_en, 0);
         chk("rstmid_ready_after", in_ready, 1);
      end

      // Redirect on lane 1 with a younger burst accepted behind it
      res_valid = 4'b1111; res_rd = {6'd4, 6'd3, 6'd2, 6'd1};
      res_data = {64'h44, 64'h33, 64'h22, 64'h11};
      res_redirect = 4'b0010; res_target = {4{64'h1000}};
      tick();
      res_rd = {6'd33, 6'd32, 6'd31, 6'd30};
      res_data = {64'hD, 64'hC, 64'hB, 64'hA};
      res_redirect = '0; res_target = '0;
      chk("redir_ready", in_ready, 1);
      tick();
      clr();
      chk("redir_wr_en", wr_en, 2'b11);
      chk("redir_addr", wr_addr, {6'd2, 6'd1});
      chk("redir_data1", wr_data[1], 64'h22);
      chk("redir_retired", retired, 2);
      chk("redir_flush", flush_valid, 1);
      chk("redir_target", flush_target, 64'h1000);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("redir_no_write", wr_en, 0);
         chk("redir_no_flush", flush_valid, 0);
         chk("redir_empty_ready", in_ready, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
